// File: rtl/execute_muldiv_unit_pkg.sv
// Shared constants and types for the RV32M execute-stage multiply/divide unit.
package execute_muldiv_unit_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_iter_core.sv
// Iteration datapath: one shift-add (multiply) or restoring step (divide) per cycle.
// hi/lo form the 64-bit product, or remainder/quotient when dividing.
module execute_muldiv_unit_iter_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        last_o,
  output logic [31:0] hi_step_o,
  output logic [31:0] lo_step_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;

  logic [32:0] mul_sum;
  logic [32:0] trial;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    trial   = {hi_q, lo_q[31]} - {1'b0, opb_q};
    if (is_div_q) begin
      // trial[32] set means the shifted remainder was below the divisor: restore
      if (!trial[32]) begin
        hi_step_o = trial[31:0];
        lo_step_o = {lo_q[30:0], 1'b1};
      end else begin
        hi_step_o = {hi_q[30:0], lo_q[31]};
        lo_step_o = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_step_o = mul_sum[32:1];
      lo_step_o = {mul_sum[0], lo_q[31:1]};
    end
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    if (load_i) begin
      hi_d     = 32'd0;
      lo_d     = op_a_i;
      opb_d    = op_b_i;
      cnt_d    = 5'd0;
      is_div_d = is_div_i;
    end else if (step_i) begin
      hi_d  = hi_step_o;
      lo_d  = lo_step_o;
      cnt_d = cnt_q + 5'd1;
    end
  end

  assign last_o = step_i && (cnt_q == 5'd31);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in E: stalls the pipe while iterating,
// then presents a registered result for the E->M register.
module execute_muldiv_unit
  import execute_muldiv_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  E_opcode_i,
  input  logic [9:0]  E_funct_i,
  input  logic [31:0] E_val1_i,
  input  logic [31:0] E_val2_i,
  input  logic        e_flush_i,
  input  logic        m_stall_i,
  output logic        e_muldiv_busy_o,
  output logic        e_muldiv_valid_o,
  output logic [31:0] e_muldiv_result_o
);

  state_e      state_q, state_d;
  funct3_e     f3_q, f3_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  funct3_e     f3;
  logic        start;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;
  logic        core_step, core_last;
  logic [31:0] hi_step, lo_step;
  logic [63:0] prod_fix;
  logic [31:0] final_res;

  always_comb begin
    f3    = funct3_e'(E_funct_i[2:0]);
    start = (state_q == ST_IDLE) && (E_opcode_i == OPCODE_OP) &&
            (E_funct_i[9:3] == FUNCT7_MULDIV) && !e_flush_i;
    a_neg = (f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && E_val1_i[31];
    b_neg = (f3 inside {F3_MULH, F3_DIV, F3_REM}) && E_val2_i[31];
    a_mag = neg_if(a_neg, E_val1_i);
    b_mag = neg_if(b_neg, E_val2_i);
    div_zero = f3[2] && (E_val2_i == 32'd0);
    div_ovf  = (f3 inside {F3_DIV, F3_REM}) && (E_val1_i == 32'h8000_0000) &&
               (E_val2_i == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    // f3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) special_res = f3[1] ? E_val1_i : 32'hFFFF_FFFF;
    else          special_res = f3[1] ? 32'd0 : 32'h8000_0000;
  end

  assign core_step = (state_q == ST_BUSY) && !e_flush_i;

  execute_muldiv_unit_iter_core u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start),
    .step_i    (core_step),
    .is_div_i  (f3[2]),
    .op_a_i    (a_mag),
    .op_b_i    (b_mag),
    .last_o    (core_last),
    .hi_step_o (hi_step),
    .lo_step_o (lo_step)
  );

  always_comb begin
    prod_fix = neg_res_q ? (~{hi_step, lo_step} + 64'd1) : {hi_step, lo_step};
    case (f3_q)
      F3_MUL:              final_res = prod_fix[31:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:            final_res = prod_fix[63:32];
      F3_DIV, F3_DIVU:     final_res = neg_if(neg_res_q, lo_step);
      default:             final_res = neg_if(neg_rem_q, hi_step);
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = special ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (e_flush_i)      state_d = ST_IDLE;
        else if (core_last) state_d = ST_DONE;
      end
      ST_DONE: if (e_flush_i || !m_stall_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    f3_d      = f3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (start) begin
      f3_d      = f3;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (special) result_d = special_res;
    end else if (core_last && !e_flush_i) begin
      result_d = final_res;
    end
  end

  // Output logic
  always_comb begin
    e_muldiv_busy_o   = (start || (state_q == ST_BUSY)) && !e_flush_i && !rst_i;
    e_muldiv_valid_o  = (state_q == ST_DONE);
    e_muldiv_result_o = result_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      f3_q      <= F3_MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed and randomized checks of execute_muldiv_unit against an arithmetic reference.
module tb_execute_muldiv_unit;

  localparam logic [6:0] OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  e_opcode;
  logic [9:0]  e_funct;
  logic [31:0] e_val1, e_val2;
  logic        e_flush, m_stall;
  logic        busy, valid;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_muldiv_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .E_opcode_i        (e_opcode),
    .E_funct_i         (e_funct),
    .E_val1_i          (e_val1),
    .E_val2_i          (e_val2),
    .e_flush_i         (e_flush),
    .m_stall_i         (m_stall),
    .e_muldiv_busy_o   (busy),
    .e_muldiv_valid_o  (valid),
    .e_muldiv_result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int stall_n, input string tag);
    logic [31:0] exp;
    logic        special, got;
    int          exp_busy, busy_cnt, cyc;
    exp      = ref_model(f3, a, b);
    special  = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_busy = special ? 1 : 33;
    @(negedge clk);
    e_opcode = OP; e_funct = {7'b0000001, f3}; e_val1 = a; e_val2 = b; m_stall = 1'b0;
    busy_cnt = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      #1;
      cyc++;
      if (busy === 1'b1) busy_cnt++;
      if (valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_timeout"}, {31'd0, got}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_valid_cycle"}, cyc, exp_busy + 1);
    check({tag, "_result"}, result, exp);
    for (int i = 0; i < stall_n; i++) begin
      m_stall = 1'b1;
      @(negedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_hold_result"}, result, exp);
    end
    m_stall = 1'b0;
    $display("op %s f3=%0d a=%h b=%h result=%h expected=%h busy=%0d stall=%0d",
             tag, f3, a, b, result, exp, busy_cnt, stall_n);
  endtask

  task automatic nop_step(input string tag);
    @(negedge clk);
    e_opcode = OP; e_funct = 10'd0; e_val1 = 32'd1; e_val2 = 32'd2;
    #1;
    check({tag, "_nop_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_nop_valid"}, {31'd0, valid}, 32'd0);
    $display("nop %s busy=%b valid=%b", tag, busy, valid);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel;
    logic        saw_valid;

    rst = 1'b1; e_flush = 1'b0; m_stall = 1'b0;
    e_opcode = OP; e_funct = {7'b0000001, 3'b000}; e_val1 = 32'd7; e_val2 = 32'd3;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    $display("reset busy=%b valid=%b result=%h", busy, valid, result);
    @(negedge clk);
    e_funct = 10'd0;
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 0, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0, "rem");
    run_op(3'b101, 32'd5, 32'd0, 0, "divu_zero");
    run_op(3'b110, 32'd5, 32'd0, 0, "rem_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'b000, 32'd12345, 32'd678, 3, "mul_stall");
    nop_step("after_stall");
    run_op(3'b101, 32'd100, 32'd7, 0, "divu_b2b");
    run_op(3'b111, 32'd100, 32'd7, 0, "remu_b2b");
    nop_step("after_b2b");

    // Flush at BUSY count 10: start cycle plus ten BUSY cycles before it
    @(negedge clk);
    e_opcode = OP; e_funct = {7'b0000001, 3'b000}; e_val1 = 32'd123; e_val2 = 32'd456;
    #1;
    check("flush_start_busy", {31'd0, busy}, 32'd1);
    repeat (11) @(negedge clk);
    e_flush = 1'b1;
    #1;
    check("flush_busy_drop", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    e_flush = 1'b0;
    e_funct = 10'd0;
    #1;
    check("flush_add_busy", {31'd0, busy}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid || busy) saw_valid = 1'b1;
    end
    check("flush_no_activity", {31'd0, saw_valid}, 32'd0);
    $display("flush test busy=%b valid=%b", busy, valid);

    // Reset in the middle of a division
    @(negedge clk);
    e_funct = {7'b0000001, 3'b100}; e_val1 = 32'd1000; e_val2 = 32'd3;
    #1;
    check("rst_start_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    e_funct = 10'd0;
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid || busy) saw_valid = 1'b1;
    end
    check("rst_no_activity", {31'd0, saw_valid}, 32'd0);
    $display("reset test valid=%b result=%h", valid, result);

    for (int n = 0; n < 20; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel < 4)  rb = 32'($urandom_range(1, 15)) ^ ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'd0);
      else               rb = $urandom;
      run_op(rf3, ra, rb, $urandom_range(0, 2), "rand");
    end
    nop_step("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
